adv7393_line_serializer: RTL and testbench

- Converts compressed pixel symbols into the timed 4:2:2 sample stream driving the ADV7393 pixel bus.
- Each symbol carries PIXELS_PER_SYMBOL stored pixels ({Y, CbCr}).
- Sits between the line-buffer read side and the output pads.
- Generates line and frame timing internally, inserts blanking, centres the active window and flags buffer underflow.
- Successor to the fixed 4-pixel/10-bit output path: pixel count, component width and output width are parametrised; line/frame geometry is runtime-configurable.

---
 rtl/adv7393_line_serializer.sv | 215 +++++++++++++++++++++
 tb/tb_adv7393_line_serializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adv7393_line_serializer.sv
// adv7393_line_serializer: turns compressed pixel symbols into the timed 4:2:2
// sample stream for the ADV7393 pixel bus. Line/frame timing, blanking, picture
// window and underflow detection are generated here.
// Optional build macro ADV7393_TRC_EN: BT.656 EAV/SAV timing reference codes
// replace the blank samples at the edges of the blanking interval.
module adv7393_line_serializer #(
    parameter int PIXELS_PER_SYMBOL = 4,
    parameter int COMP_W            = 8,
    parameter int OUT_DWIDTH        = 10,
    parameter int CNT_W             = 12,
    parameter int HSYNC_W           = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [CNT_W-1:0]                      cfg_blank_len,
    input  logic [CNT_W-1:0]                      cfg_active_len,
    input  logic [CNT_W-1:0]                      cfg_lines,
    input  logic [CNT_W-1:0]                      cfg_act_start,
    input  logic [CNT_W-1:0]                      cfg_act_stop,
    input  logic [CNT_W-1:0]                      cfg_field_line,
    input  logic [2*COMP_W*PIXELS_PER_SYMBOL-1:0] s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [OUT_DWIDTH-1:0]                 dout,
    output logic                                  hsync,
    output logic                                  frame_start,
    output logic                                  underflow,
    input  logic                                  underflow_clr
);

    localparam int PIX_W = 2 * COMP_W;
    localparam int SYM_W = PIX_W * PIXELS_PER_SYMBOL;
    localparam int GRP_W = $clog2(2 * PIXELS_PER_SYMBOL);
    localparam int SHIFT = OUT_DWIDTH - COMP_W;

    localparam logic [OUT_DWIDTH-1:0] BLANK_CBCR = OUT_DWIDTH'(8'h80) << (OUT_DWIDTH - 8);
    localparam logic [OUT_DWIDTH-1:0] BLANK_Y    = OUT_DWIDTH'(8'h10) << (OUT_DWIDTH - 8);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ACTIVE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        tick_q, tick_d;
    logic [CNT_W-1:0]        line_q, line_d;
    logic                    grp_ok_q, grp_ok_d;
    logic [OUT_DWIDTH-1:0]   dout_q, dout_d;
    logic                    hsync_q, hsync_d;
    logic                    fs_q, fs_d;
    logic                    uf_q, uf_d;
    logic [SYM_W-1:0]        sym_q;
    logic                    sym_load;

    logic                    picture;
    logic [GRP_W-1:0]        grp;
    logic [GRP_W-1:0]        pix_sel;
    logic [PIX_W-1:0]        cur_pix;
    logic [OUT_DWIDTH-1:0]   blank_val;
    logic                    last_blank;
    logic                    last_active;
    logic                    last_line;

    // Left-justify a stored component onto the output bus.
    function automatic logic [OUT_DWIDTH-1:0] map_comp(input logic [COMP_W-1:0] c);
        return OUT_DWIDTH'(c) << SHIFT;
    endfunction

    assign picture     = (line_q >= cfg_act_start) && (line_q < cfg_act_stop);
    assign grp         = tick_q[GRP_W-1:0];
    assign pix_sel     = grp >> 1;
    assign cur_pix     = sym_q[int'(pix_sel) * PIX_W +: PIX_W];
    assign blank_val   = tick_q[0] ? BLANK_Y : BLANK_CBCR;
    assign last_blank  = (tick_q == cfg_blank_len - CNT_W'(1));
    assign last_active = (tick_q == cfg_active_len - CNT_W'(1));
    assign last_line   = (line_q == cfg_lines - CNT_W'(1));

`ifdef ADV7393_TRC_EN
    localparam int TRC_W = OUT_DWIDTH + 10;
    localparam logic [TRC_W-1:0]      TRC_FF_WIDE = TRC_W'(10'h3FF) << OUT_DWIDTH;
    localparam logic [OUT_DWIDTH-1:0] TRC_FF      = TRC_FF_WIDE[TRC_W-1 -: OUT_DWIDTH];

    logic                  trc_hit;
    logic                  trc_f, trc_v, trc_h;
    logic [1:0]            trc_idx;
    logic [7:0]            trc_xy;
    logic [OUT_DWIDTH-1:0] trc_word;

    // EAV occupies the first four blanking ticks, SAV the last four.
    always_comb begin
        trc_hit = 1'b0;
        trc_h   = 1'b0;
        trc_idx = 2'd0;
        trc_f   = (line_q >= cfg_field_line);
        trc_v   = ~picture;
        if (tick_q < CNT_W'(4)) begin
            trc_hit = 1'b1;
            trc_h   = 1'b1;
            trc_idx = tick_q[1:0];
        end else if (tick_q >= cfg_blank_len - CNT_W'(4)) begin
            trc_hit = 1'b1;
            trc_idx = tick_q[1:0] - cfg_blank_len[1:0];
        end
        trc_xy = {1'b1, trc_f, trc_v, trc_h, trc_v ^ trc_h, trc_f ^ trc_h,
                  trc_f ^ trc_v, trc_f ^ trc_v ^ trc_h};
        case (trc_idx)
            2'd0:    trc_word = TRC_FF;
            2'd3:    trc_word = OUT_DWIDTH'(trc_xy) << (OUT_DWIDTH - 8);
            default: trc_word = '0;
        endcase
    end
`else
    logic unused_field_line;
    assign unused_field_line = ^cfg_field_line;
`endif

    // Next-state, counters and the sample for the current tick.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        tick_d   = tick_q;
        line_d   = line_q;
        grp_ok_d = grp_ok_q;
        dout_d   = '0;
        hsync_d  = 1'b0;
        fs_d     = 1'b0;
        s_ready  = 1'b0;
        sym_load = 1'b0;
        uf_d     = uf_q & ~underflow_clr;
        case (state_q)
            S_IDLE: begin
                tick_d   = '0;
                line_d   = '0;
                grp_ok_d = 1'b0;
                if (en) state_d = S_BLANK;
            end
            S_BLANK: begin
                dout_d = blank_val;
`ifdef ADV7393_TRC_EN
                if (trc_hit) dout_d = trc_word;
`endif
                hsync_d = (tick_q < CNT_W'(HSYNC_W));
                fs_d    = (line_q == '0) && (tick_q == '0);
                if (last_blank) begin
                    tick_d  = '0;
                    state_d = S_ACTIVE;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                dout_d = blank_val;
                if (picture) begin
                    if (grp == '0) begin
                        if (s_valid) begin
                            s_ready  = 1'b1;
                            sym_load = 1'b1;
                            grp_ok_d = 1'b1;
                            dout_d   = map_comp(s_data[COMP_W-1:0]);
                        end else begin
                            grp_ok_d = 1'b0;
                            uf_d     = 1'b1;
                        end
                    end else if (grp_ok_q) begin
                        dout_d = tick_q[0] ? map_comp(cur_pix[PIX_W-1:COMP_W])
                                           : map_comp(cur_pix[COMP_W-1:0]);
                    end
                end
                if (last_active) begin
                    tick_d   = '0;
                    grp_ok_d = 1'b0;
                    line_d   = last_line ? '0 : line_q + CNT_W'(1);
                    state_d  = en ? S_BLANK : S_IDLE;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            line_q   <= '0;
            grp_ok_q <= 1'b0;
            dout_q   <= '0;
            hsync_q  <= 1'b0;
            fs_q     <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q  <= state_d;
            tick_q   <= tick_d;
            line_q   <= line_d;
            grp_ok_q <= grp_ok_d;
            dout_q   <= dout_d;
            hsync_q  <= hsync_d;
            fs_q     <= fs_d;
            uf_q     <= uf_d;
        end
    end

    // Symbol holding register, loaded on each accepted symbol.
    always_ff @(posedge clk) begin
        // NOTE: data-only register left out of reset; grp_ok_q gates any use of stale contents.
        if (sym_load) sym_q <= s_data;
    end

    assign dout        = dout_q;
    assign hsync       = hsync_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;

endmodule

// File: tb/tb_adv7393_line_serializer.sv
// Directed bench for adv7393_line_serializer with default parameters
// (4 pixels/symbol, 8-bit components, 10-bit output).
module tb_adv7393_line_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] cfg_blank_len, cfg_active_len, cfg_lines;
    logic [11:0] cfg_act_start, cfg_act_stop, cfg_field_line;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  dout;
    logic        hsync;
    logic        frame_start;
    logic        underflow;
    logic        underflow_clr;

    adv7393_line_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .cfg_blank_len  (cfg_blank_len),
        .cfg_active_len (cfg_active_len),
        .cfg_lines      (cfg_lines),
        .cfg_act_start  (cfg_act_start),
        .cfg_act_stop   (cfg_act_stop),
        .cfg_field_line (cfg_field_line),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .dout           (dout),
        .hsync          (hsync),
        .frame_start    (frame_start),
        .underflow      (underflow),
        .underflow_clr  (underflow_clr)
    );

    always #5 clk = ~clk;

    // Pixel i = {Y, CbCr} at bits [i*16 +: 16].
    localparam logic [63:0] SYM_A = 64'h7788_5566_3344_1122;
    localparam logic [63:0] SYM_B = 64'h01FE_3CC3_8001_FF00;
    localparam logic [63:0] SYM_X = 64'hDEAD_BEEF_CAFE_F00D;

    logic [9:0] a_exp [8] = '{10'h088, 10'h044, 10'h110, 10'h0CC, 10'h198, 10'h154, 10'h220, 10'h1DC};
    logic [9:0] b_exp [8] = '{10'h000, 10'h3FC, 10'h004, 10'h200, 10'h30C, 10'h0F0, 10'h3F8, 10'h004};

`ifdef ADV7393_TRC_EN
    localparam logic [9:0] EXP_T0 = 10'h3FF;
    // XY words hand-derived for lines 0..3 with window 1..3 and field line 2.
    logic [9:0] eav_xy [4] = '{10'h2D8, 10'h274, 10'h368, 10'h3C4};
    logic [9:0] sav_xy [4] = '{10'h2AC, 10'h200, 10'h31C, 10'h3B0};

    function automatic logic [9:0] trc_exp(input int ln, input int tk);
        int idx;
        idx = (tk < 4) ? tk : tk - 12;
        if (idx == 0) return 10'h3FF;
        if (idx == 3) return (tk < 4) ? eav_xy[ln] : sav_xy[ln];
        return 10'h000;
    endfunction
`else
    localparam logic [9:0] EXP_T0 = 10'h200;
`endif

    typedef struct {
        logic        en;
        logic        valid;
        logic [63:0] data;
        logic        clr;
        logic [9:0]  exp_dout;
        logic        exp_hsync;
        logic        exp_fs;
        logic        exp_ready;
        logic        exp_uf;
    } vec_t;

    localparam int NVEC = 200;
    vec_t tbl [NVEC];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [11:0] active, input logic [11:0] start);
        cfg_blank_len  = 12'd16;
        cfg_active_len = active;
        cfg_lines      = 12'd4;
        cfg_act_start  = start;
        cfg_act_stop   = 12'd3;
        cfg_field_line = 12'd2;
    endtask

    // Hold reset, check the reset state, release on a falling edge.
    task automatic do_reset(input string tag);
        rst           = 1'b1;
        en            = 1'b1;
        s_valid       = 1'b0;
        s_data        = SYM_X;
        underflow_clr = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_dout"},  0, dout, 0);
        check({tag, "_hsync"}, 0, hsync, 0);
        check({tag, "_fs"},    0, frame_start, 0);
        check({tag, "_ready"}, 0, s_ready, 0);
        check({tag, "_uf"},    0, underflow, 0);
        rst = 1'b0;
    endtask

    // Wait (bounded) for the falling edge showing line 0, blank tick 0.
    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("sync_frame_start", 0, ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=0 got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int ln, tk;

        // Vector table: frame 1 plus the first lines of frame 2 (32 ticks per line).
        for (int n = 0; n < NVEC; n++) begin
            ln = (n / 32) % 4;
            tk = n % 32;
            tbl[n] = '{en: 1'b1, valid: 1'b0, data: SYM_X, clr: 1'b0,
                       exp_dout: (n % 2 == 0) ? 10'h200 : 10'h040,
                       exp_hsync: (tk < 4), exp_fs: (tk == 0 && ln == 0), exp_ready: 1'b0,
                       exp_uf: ((n >= 56 && n <= 140) || (n >= 176 && n <= 178))};
`ifdef ADV7393_TRC_EN
            if (tk < 4 || (tk >= 12 && tk < 16)) tbl[n].exp_dout = trc_exp(ln, tk);
`endif
        end
        tbl[47].valid = 1'b1; tbl[47].data = SYM_A; tbl[47].exp_ready = 1'b1;
        tbl[79].valid = 1'b1; tbl[79].data = SYM_B; tbl[79].exp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tbl[48 + i].exp_dout  = a_exp[i];
            tbl[80 + i].exp_dout  = b_exp[i];
            tbl[184 + i].exp_dout = a_exp[i];
        end
        tbl[140].clr = 1'b1;
        tbl[175].clr = 1'b1;
        tbl[178].clr = 1'b1;
        for (int n = 177; n <= 183; n++) begin
            tbl[n].valid = 1'b1;
            tbl[n].data  = SYM_A;
        end
        tbl[183].exp_ready = 1'b1;

        // Reset state, then the table-driven frames.
        set_cfg(12'd16, 12'd1);
        do_reset("rst1");
        sync_frame(ok);
        if (ok) begin
            for (int n = 0; n < NVEC; n++) begin
                if (n > 0) @(negedge clk);
                en            = tbl[n].en;
                s_valid       = tbl[n].valid;
                s_data        = tbl[n].data;
                underflow_clr = tbl[n].clr;
                #1;
                check("dout",        n, dout,        tbl[n].exp_dout);
                check("hsync",       n, hsync,       tbl[n].exp_hsync);
                check("frame_start", n, frame_start, tbl[n].exp_fs);
                check("s_ready",     n, s_ready,     tbl[n].exp_ready);
                check("underflow",   n, underflow,   tbl[n].exp_uf);
            end
        end
        s_valid       = 1'b0;
        underflow_clr = 1'b0;

        // Active length 12: two symbols per line, second one only half used.
        set_cfg(12'd12, 12'd1);
        do_reset("rst2");
        sync_frame(ok);
        if (ok) begin
            for (int n = 1; n <= 72; n++) begin
                @(negedge clk);
                s_valid = (n >= 43 && n <= 51) || (n == 71);
                s_data  = (n == 43 || n == 71) ? SYM_A : (n >= 44 && n <= 51) ? SYM_B : SYM_X;
                #1;
                if (n >= 43 && n <= 51) check("p12_ready", n, s_ready, (n == 43 || n == 51));
                if (n >= 44 && n <= 51) check("p12_dout_a", n, dout, a_exp[n - 44]);
                if (n >= 52 && n <= 55) check("p12_dout_b", n, dout, b_exp[n - 52]);
                if (n == 56) begin
                    check("p12_next_hsync", n, hsync, 1);
                    check("p12_next_dout", n, dout, EXP_T0);
                end
                if (n == 71) check("p12_line2_ready", n, s_ready, 1);
                if (n == 72) begin
                    check("p12_line2_dout", n, dout, 10'h088);
                    check("p12_uf", n, underflow, 0);
                end
            end
        end
        s_valid = 1'b0;

        // en dropped mid-line, restart, then reset asserted mid-active.
        set_cfg(12'd16, 12'd0);
        do_reset("rst3");
        sync_frame(ok);
        if (ok) begin
            for (int n = 1; n <= 65; n++) begin
                @(negedge clk);
                en      = !(n >= 20 && n < 40);
                s_valid = (n >= 57);
                s_data  = (n >= 57) ? SYM_A : SYM_X;
                #1;
                if (n == 26) check("en_mid_dout", n, dout, 10'h200);
                if (n == 31) check("en_last_dout", n, dout, 10'h040);
                if (n == 32 || n == 39) begin
                    check("idle_dout", n, dout, 0);
                    check("idle_hsync", n, hsync, 0);
                end
                if (n == 42) check("restart_fs", n, frame_start, 1);
                if (n == 57) check("restart_ready", n, s_ready, 1);
                if (n == 60) check("restart_dout", n, dout, 10'h110);
                if (n == 65) begin
                    check("pre_rst_ready", n, s_ready, 1);
                    #1 rst = 1'b1;
                    #1;
                    check("async_rst_dout", n, dout, 0);
                    check("async_rst_ready", n, s_ready, 0);
                    check("async_rst_uf", n, underflow, 0);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
